uart_rx_framer: RTL and testbench
=================================

// Module: uart_rx_framer
// PURPOSE
//  Parametrised UART receive framer: synchronises and oversamples rx_i, majority-votes each bit,
//  recovers a character of DATA_BITS bits and checks optional parity and 1/2 stop bits.
//  Reports framing, parity and break conditions. Sits between the pad and the RX FIFO of uart_lite.
// PARAMETERS
//  OVERSAMPLING  16  clk_i cycles per bit; even, >= 8 (elaboration error otherwise)
//  DATA_BITS     8   character width, 5..9 (elaboration error otherwise)
//  PARITY        0   0 = none, 1 = odd, 2 = even
//  STOP_BITS     1   1 or 2
//  SYNC_STAGES   2   rx_i synchroniser depth, >= 2
// PORTS
//  clk_i         in   1          single clock
//  rst_ni        in   1          asynchronous, active-low reset
//  rx_i          in   1          serial line, idle high, asynchronous to clk_i
//  char_o        out  DATA_BITS  last received character, LSB = first data bit
//  valid_o       out  1          one-cycle pulse: char_o and error flags are valid
//  parity_err_o  out  1          qualified by valid_o; parity bit mismatch (always 0 when PARITY = 0)
//  frame_err_o   out  1          qualified by valid_o; a stop bit sampled 0
//  break_o       out  1          one-cycle pulse: break detected (valid_o stays 0)
//  busy_o        out  1          high from start-edge detection until return to IDLE
// BEHAVIOUR
//  N = 1 + DATA_BITS + (PARITY != 0) + STOP_BITS bits per frame; H = OVERSAMPLING/2.
//  Reset (rst_ni = 0, async): synchroniser flops = 1; char_o = 0; valid_o, parity_err_o,
//   frame_err_o, break_o, busy_o = 0; FSM = IDLE. Reset mid-frame discards the frame without a pulse.
//  rxs = synchronised rx_i. All timing below is relative to rxs.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE | WAIT_IDLE.
//  IDLE: t0 = first cycle where rxs = 0 and the previous rxs = 1. Go to START; busy_o = 1.
//  Bit k (k = 0 is the start bit) has centre cycle c_k = t0 + H + k*OVERSAMPLING.
//   Its value is the majority of rxs at c_k-1, c_k, c_k+1, decided at c_k+1.
//  START: a voted 1 is a false start -> IDLE; no pulse; busy_o = 0 on the next cycle.
//  DATA: shift the voted bits in LSB first. PARITY: compare the voted bit with the XOR of the
//   data bits (odd: XOR must be inverted).
//  STOP: vote every stop bit. On the cycle after the last stop decision (c_{N-1}+2):
//   - any stop bit 0, and all data bits, the parity bit and every stop bit 0:
//     break_o = 1, valid_o = 0, char_o unchanged -> WAIT_IDLE
//   - any other stop bit 0: valid_o = 1, frame_err_o = 1, char_o updated -> WAIT_IDLE
//   - all stop bits 1: valid_o = 1, frame_err_o = 0, char_o updated -> IDLE
//   - parity_err_o is set with valid_o whenever the parity check failed.
//  WAIT_IDLE: stay until rxs = 1 for one cycle, then IDLE. This gives a single break_o per break
//   and prevents a retrigger inside a low line.
//  valid_o, break_o and the flags are high for exactly one cycle. The flags are 0 whenever
//   valid_o = 0. char_o holds its value between pulses.
//  Latency: rxs falling edge at t0 -> pulse at t0 + H + (N-1)*OVERSAMPLING + 2.
//  Throughput: the next start edge is accepted in the cycle after the pulse. Consecutive valid_o
//   pulses are >= N*OVERSAMPLING cycles apart (8N1 at 16x: 160).
//  Bit counter width is clog2(N+1). Sample counter width is clog2(OVERSAMPLING); it wraps at
//   OVERSAMPLING-1 -> 0.
// TESTING
//  8N1, 16x, send 0x A5 cleanly -> one valid_o, char_o = 0xA5, no flags, at t0+8+9*16+2.
//  PARITY = 2, send 0x01 with parity bit 0 -> valid_o, char_o = 0x01, parity_err_o = 1.
//  rx_i low for 3 cycles then high -> no pulse; busy_o returns to 0 within H+3 cycles.
//  Send 0x55 with stop bit 0, then line high -> valid_o, frame_err_o = 1; next 0x3C received
//   cleanly with no flags.
//  Hold rx_i low for 20 bit times, then send 0x7E -> exactly one break_o, no valid_o; then
//   valid_o with char_o = 0x7E.
//  Back-to-back 8N1 frames 0x00, 0xFF -> pulses exactly 160 cycles apart.
//  Assert rst_ni mid-frame -> all outputs 0 immediately and no pulse; the next frame is
//   received correctly.
//  Single-cycle glitch at one bit centre -> majority vote rejects it and char_o is unaffected.

Source files
------------

// File: rtl/uart_rx_framer.sv
// uart_rx_framer: oversampling UART receive framer.
// The serial line is synchronised and each bit is decided by a 3-sample majority vote
// around its centre. The framer checks optional parity and 1 or 2 stop bits, and
// reports framing errors, parity errors and line breaks.
module uart_rx_framer #(
    parameter int OVERSAMPLING = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] char_o,
    output logic                 valid_o,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 break_o,
    output logic                 busy_o
);
    // Frame geometry: start + data + optional parity + stop bits.
    localparam int N  = 1 + DATA_BITS + ((PARITY != 0) ? 1 : 0) + STOP_BITS;
    localparam int H  = OVERSAMPLING / 2;
    localparam int CW = $clog2(OVERSAMPLING);
    localparam int BW = $clog2(N + 1);

    // The vote is taken one cycle after the bit centre, once the c+1 sample is present.
    localparam logic [CW-1:0] CNT_DECIDE    = CW'(H + 1);
    localparam logic [CW-1:0] CNT_LAST      = CW'(OVERSAMPLING - 1);
    localparam logic [BW-1:0] BIT_LAST_DATA = BW'(DATA_BITS);
    localparam logic [BW-1:0] BIT_LAST      = BW'(N - 1);
    localparam logic          PAR_ODD       = (PARITY == 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_PARITY    = 3'd3;
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;

    // Reject unsupported configurations at elaboration.
    generate
        if (OVERSAMPLING < 8 || (OVERSAMPLING % 2) != 0) begin : g_bad_oversampling
            $error("uart_rx_framer: OVERSAMPLING must be even and >= 8");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_rx_framer: DATA_BITS must be 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_rx_framer: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_rx_framer: STOP_BITS must be 1 or 2");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("uart_rx_framer: SYNC_STAGES must be >= 2");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rxs_d1;
    logic                   r_rxs_d2;
    logic [2:0]             r_state;
    logic [CW-1:0]          r_cnt;
    logic [BW-1:0]          r_bit;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par_err;
    logic                   r_stop_bad;
    logic                   r_all_zero;
    logic [DATA_BITS-1:0]   r_char;
    logic                   r_valid;
    logic                   r_perr;
    logic                   r_ferr;
    logic                   r_break;
    logic                   r_busy;

    logic w_rxs;
    logic w_start_edge;
    logic w_decide;
    logic w_vote;
    logic w_par_exp;
    logic w_stop_bad_n;
    logic w_zero_n;

    assign w_rxs        = r_sync[SYNC_STAGES-1];
    assign w_start_edge = r_rxs_d1 & ~w_rxs;
    assign w_decide     = (r_cnt == CNT_DECIDE);
    // Majority of the samples at c-1 (d2), c (d1) and c+1 (current).
    assign w_vote       = (w_rxs & r_rxs_d1) | (w_rxs & r_rxs_d2) | (r_rxs_d1 & r_rxs_d2);
    assign w_par_exp    = (^r_shift) ^ PAR_ODD;
    // Stop and all-zero status including the stop bit being voted this cycle.
    assign w_stop_bad_n = r_stop_bad | ~w_vote;
    assign w_zero_n     = r_all_zero & ~w_vote;

    // Synchronise the line and keep two cycles of history for the vote and edge detect.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync   <= '1;
            r_rxs_d1 <= 1'b1;
            r_rxs_d2 <= 1'b1;
        end else begin
            // NOTE: non-blocking so every stage captures its neighbour's pre-edge value.
            r_sync   <= {r_sync[SYNC_STAGES-2:0], rx_i};
            r_rxs_d1 <= w_rxs;
            r_rxs_d2 <= r_rxs_d1;
        end
    end

    // Frame FSM with sample/bit counters, data shifter and result registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_par_err  <= 1'b0;
            r_stop_bad <= 1'b0;
            r_all_zero <= 1'b0;
            r_char     <= '0;
            r_valid    <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_break    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            // NOTE: pulses default low here so each is high for exactly one cycle.
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_break <= 1'b0;

            if (r_state != S_IDLE && r_state != S_WAIT_IDLE) begin
                r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start_edge) begin
                        r_state <= S_START;
                        r_busy  <= 1'b1;
                        r_cnt   <= CW'(1);
                        r_bit   <= '0;
                    end
                end
                S_START: begin
                    if (w_decide) begin
                        if (w_vote) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state    <= S_DATA;
                            r_bit      <= BW'(1);
                            r_par_err  <= 1'b0;
                            r_stop_bad <= 1'b0;
                            r_all_zero <= 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (w_decide) begin
                        r_shift    <= {w_vote, r_shift[DATA_BITS-1:1]};
                        r_all_zero <= r_all_zero & ~w_vote;
                        r_bit      <= r_bit + 1'b1;
                        if (r_bit == BIT_LAST_DATA) begin
                            r_state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_decide) begin
                        r_par_err  <= (w_vote != w_par_exp);
                        r_all_zero <= r_all_zero & ~w_vote;
                        r_bit      <= r_bit + 1'b1;
                        r_state    <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_decide) begin
                        r_stop_bad <= w_stop_bad_n;
                        r_all_zero <= w_zero_n;
                        r_bit      <= r_bit + 1'b1;
                        if (r_bit == BIT_LAST) begin
                            if (w_zero_n) begin
                                r_break <= 1'b1;
                                r_state <= S_WAIT_IDLE;
                            end else begin
                                r_valid <= 1'b1;
                                r_char  <= r_shift;
                                r_perr  <= r_par_err;
                                r_ferr  <= w_stop_bad_n;
                                r_state <= w_stop_bad_n ? S_WAIT_IDLE : S_IDLE;
                            end
                            // Busy stays up through WAIT_IDLE after any bad stop bit.
                            r_busy <= w_stop_bad_n;
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    if (w_rxs) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign char_o       = r_char;
    assign valid_o      = r_valid;
    assign parity_err_o = r_perr;
    assign frame_err_o  = r_ferr;
    assign break_o      = r_break;
    assign busy_o       = r_busy;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Scoreboard bench for uart_rx_framer: an 8N1 instance and an 8E1 instance.
// Stimulus pushes expected pulses (value, flags, arrival cycle); monitors pop and compare.
module tb_uart_rx_framer;
    localparam int OS     = 16;
    localparam int H      = OS / 2;
    localparam int SYNC   = 2;
    // Cycles from driving the start bit on rx_i to the pulse: sync + H + (N-1)*OS + 2.
    localparam int LAT_8N1 = SYNC + H + 9 * OS + 2;
    localparam int LAT_8E1 = SYNC + H + 10 * OS + 2;

    typedef struct {
        logic [7:0] ch;
        logic       perr;
        logic       ferr;
        logic       brk;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic       rx_p;
    logic [7:0] char_m, char_p;
    logic       valid_m, valid_p;
    logic       perr_m, perr_p;
    logic       ferr_m, ferr_p;
    logic       brk_m, brk_p;
    logic       busy_m, busy_p;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    exp_t q_main[$];
    exp_t q_par[$];
    logic [7:0] last_char_m = 8'h00;

    uart_rx_framer #(.OVERSAMPLING(OS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                     .SYNC_STAGES(SYNC)) dut (
        .clk_i(clk), .rst_ni(rst_n), .rx_i(rx), .char_o(char_m), .valid_o(valid_m),
        .parity_err_o(perr_m), .frame_err_o(ferr_m), .break_o(brk_m), .busy_o(busy_m)
    );

    uart_rx_framer #(.OVERSAMPLING(OS), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1),
                     .SYNC_STAGES(SYNC)) dut_p (
        .clk_i(clk), .rst_ni(rst_n), .rx_i(rx_p), .char_o(char_p), .valid_o(valid_p),
        .parity_err_o(perr_p), .frame_err_o(ferr_p), .break_o(brk_p), .busy_o(busy_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare one observed pulse against the head of the selected queue.
    task automatic check_pulse(input int which, input logic [7:0] ch, input logic v,
                               input logic pe, input logic fe, input logic bk);
        exp_t  e;
        string p;
        p = (which == 0) ? "main_" : "par_";
        if ((which == 0 && q_main.size() == 0) || (which == 1 && q_par.size() == 0)) begin
            n_checks++;
            n_errors++;
            $display("FAIL %sunexpected_pulse: got valid=%0b break=%0b char=0x%0h, expected none",
                     p, v, bk, ch);
        end else begin
            e = (which == 0) ? q_main.pop_front() : q_par.pop_front();
            check({p, "break"}, 32'(bk), 32'(e.brk));
            check({p, "valid"}, 32'(v), 32'(!e.brk));
            check({p, "char"}, 32'(ch), 32'(e.ch));
            check({p, "parity_err"}, 32'(pe), 32'(e.perr));
            check({p, "frame_err"}, 32'(fe), 32'(e.ferr));
            check({p, "cycle"}, 32'(cyc), 32'(e.cyc));
        end
    endtask

    // Monitors sample on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid_m || brk_m) check_pulse(0, char_m, valid_m, perr_m, ferr_m, brk_m);
            else if (perr_m || ferr_m) check("main_flags_without_valid", {30'd0, perr_m, ferr_m}, 32'd0);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (valid_p || brk_p) check_pulse(1, char_p, valid_p, perr_p, ferr_p, brk_p);
            else if (perr_p || ferr_p) check("par_flags_without_valid", {30'd0, perr_p, ferr_p}, 32'd0);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive bits[0] first, OS cycles per bit; optionally invert one cycle at a bit centre.
    task automatic send_bits(input int line, input logic [15:0] bits, input int n,
                             input int glitch_bit);
        logic b;
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < OS; j++) begin
                b = bits[k];
                if (k == glitch_bit && j == H) b = ~b;
                if (line == 0) rx = b;
                else rx_p = b;
                @(posedge clk);
                #1;
            end
        end
    endtask

    function automatic logic [15:0] f8n1(input logic [7:0] d, input logic stop);
        return {6'b0, stop, d, 1'b0};
    endfunction

    function automatic logic [15:0] f8e1(input logic [7:0] d, input logic par);
        return {5'b0, 1'b1, par, d, 1'b0};
    endfunction

    // Push the expectation, then send one 8N1 frame on the main line.
    task automatic frame_main(input logic [7:0] d, input logic stop, input logic exp_ferr,
                              input int glitch_bit);
        exp_t e;
        e.ch = d; e.perr = 1'b0; e.ferr = exp_ferr; e.brk = 1'b0; e.cyc = cyc + LAT_8N1;
        q_main.push_back(e);
        last_char_m = d;
        send_bits(0, f8n1(d, stop), 10, glitch_bit);
    endtask

    task automatic frame_par(input logic [7:0] d, input logic par, input logic exp_perr);
        exp_t e;
        e.ch = d; e.perr = exp_perr; e.ferr = 1'b0; e.brk = 1'b0; e.cyc = cyc + LAT_8E1;
        q_par.push_back(e);
        send_bits(1, f8e1(d, par), 11, -1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        exp_t e;
        bit   seen;
        rst_n = 1'b0;
        rx    = 1'b1;
        rx_p  = 1'b1;
        idle(3);
        check("reset_char", 32'(char_m), 32'h0);
        check("reset_valid", 32'(valid_m), 32'h0);
        check("reset_busy", 32'(busy_m), 32'h0);
        check("reset_break", 32'(brk_m), 32'h0);
        rst_n = 1'b1;
        idle(5);
        check("idle_busy", 32'(busy_m), 32'h0);

        // Clean 0xA5.
        frame_main(8'hA5, 1'b1, 1'b0, -1);
        idle(20);

        // Three-cycle low pulse: false start, busy drops shortly after.
        rx = 1'b0;
        idle(3);
        check("false_start_busy_high", 32'(busy_m), 32'h1);
        rx = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < H + 3; i++) begin
            idle(1);
            if (!busy_m) seen = 1'b1;
        end
        check("false_start_busy_low", 32'(seen), 32'h1);
        idle(30);

        // Stop bit 0 -> frame error, then clean 0x3C.
        frame_main(8'h55, 1'b0, 1'b1, -1);
        rx = 1'b1;
        idle(20);
        frame_main(8'h3C, 1'b1, 1'b0, -1);
        idle(20);

        // Break: 20 bit times low, one break pulse with char held, then 0x7E.
        e.ch = last_char_m; e.perr = 1'b0; e.ferr = 1'b0; e.brk = 1'b1; e.cyc = cyc + LAT_8N1;
        q_main.push_back(e);
        rx = 1'b0;
        idle(20 * OS);
        rx = 1'b1;
        idle(2 * OS);
        frame_main(8'h7E, 1'b1, 1'b0, -1);
        idle(20);

        // Glitch at the centre of data bit 2 (a 0 in 0xC3) must be voted out.
        frame_main(8'hC3, 1'b1, 1'b0, 3);
        idle(20);

        // Back-to-back frames: pulses exactly 160 cycles apart via expected cycles.
        frame_main(8'h00, 1'b1, 1'b0, -1);
        frame_main(8'hFF, 1'b1, 1'b0, -1);
        idle(20);

        // Reset mid-frame: outputs clear at once, no pulse, next frame is fine.
        send_bits(0, f8n1(8'h12, 1'b1), 4, -1);
        check("midframe_busy", 32'(busy_m), 32'h1);
        rst_n = 1'b0;
        #1;
        check("midreset_busy", 32'(busy_m), 32'h0);
        check("midreset_char", 32'(char_m), 32'h0);
        check("midreset_valid", 32'(valid_m), 32'h0);
        rx = 1'b1;
        idle(3);
        rst_n = 1'b1;
        idle(10);
        frame_main(8'h99, 1'b1, 1'b0, -1);
        idle(20);

        // Even parity instance: 0x01 needs parity 1, send 0 -> error; 0x03 with 0 is clean.
        frame_par(8'h01, 1'b0, 1'b1);
        idle(20);
        frame_par(8'h03, 1'b0, 1'b0);
        idle(20);

        for (int i = 0; i < 400 && (q_main.size() != 0 || q_par.size() != 0); i++) idle(1);
        check("main_scoreboard_empty", 32'(q_main.size()), 32'h0);
        check("par_scoreboard_empty", 32'(q_par.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
